// File: rtl/t05_huffman_pkg.sv
// Shared types and codebook-entry helpers for the streaming Huffman decoder.
package t05_huffman_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_SCAN,
        ST_EMIT,
        ST_DONE,
        ST_ERROR
    } huff_state_t;

    // Entries are handled in a container wide enough for any supported geometry.
    localparam int unsigned CB_LEN_MAX_W  = 16;
    localparam int unsigned CB_CODE_MAX_W = 256;
    localparam int unsigned CB_MAX_W      = CB_LEN_MAX_W + CB_CODE_MAX_W;

    typedef logic [CB_MAX_W-1:0] cb_word_t;

    function automatic logic [CB_LEN_MAX_W-1:0] cb_entry_len(input cb_word_t entry,
                                                             input int unsigned code_w);
        return CB_LEN_MAX_W'(entry >> code_w);
    endfunction

    function automatic logic [CB_CODE_MAX_W-1:0] cb_entry_code(input cb_word_t entry,
                                                               input int unsigned code_w);
        logic [CB_CODE_MAX_W-1:0] mask;
        mask = ~({CB_CODE_MAX_W{1'b1}} << code_w);
        return CB_CODE_MAX_W'(entry) & mask;
    endfunction

endpackage

// File: rtl/t05_huffman_stream_decode_if.sv
// Byte input, codebook read port and symbol output of the Huffman decoder.
interface t05_huffman_stream_decode_if #(
    parameter int unsigned SYM_W   = 8,
    parameter int unsigned MAX_LEN = 127,
    parameter int unsigned LEN_W   = 7
);
    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   cb_rd_en;
    logic [SYM_W-1:0]       cb_addr;
    logic [LEN_W+MAX_LEN-1:0] cb_data;
    logic [SYM_W-1:0]       sym_data;
    logic                   sym_valid;
    logic                   sym_ready;

    modport master (
        input  in_data, in_valid, cb_data, sym_ready,
        output in_ready, cb_rd_en, cb_addr, sym_data, sym_valid
    );

    modport slave (
        output in_data, in_valid, cb_data, sym_ready,
        input  in_ready, cb_rd_en, cb_addr, sym_data, sym_valid
    );
endinterface

// File: rtl/t05_bit_unpacker.sv
// Byte load and MSB-first bit shifter; accepts a byte whenever the decoder is fetching.
module t05_bit_unpacker (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch_en,
    input  logic       shift_en,
    input  logic       discard,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready_c,
    output logic       load_c,
    output logic       bit_c,
    output logic [3:0] bits_left
);
    logic [7:0] sreg;

    assign in_ready_c = fetch_en;
    assign load_c     = fetch_en && in_valid;
    assign bit_c      = sreg[7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg      <= '0;
            bits_left <= '0;
        end else if (discard) begin
            sreg      <= '0;
            bits_left <= '0;
        end else if (load_c) begin
            sreg      <= in_data;
            bits_left <= 4'd8;
        end else if (shift_en) begin
            sreg      <= {sreg[6:0], 1'b0};
            bits_left <= bits_left - 4'd1;
        end
    end
endmodule

// File: rtl/t05_huffman_stream_decode.sv
// Streaming Huffman decoder: shifts bits MSB-first and linearly scans an external codebook per bit.
module t05_huffman_stream_decode
    import t05_huffman_pkg::*;
#(
    parameter int unsigned SYM_W   = 8,
    parameter int unsigned MAX_LEN = 127,
    parameter int unsigned LEN_W   = 7,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     tot_syms,
    t05_huffman_stream_decode_if.master bus,
    output logic [CNT_W-1:0]     sym_count,
    output logic                 finished,
    output logic                 error
);
    localparam int unsigned NUM_SYMS = 2 ** SYM_W;
    localparam int unsigned IDX_W    = SYM_W + 1;

    huff_state_t        state, state_nxt;
    logic [CNT_W-1:0]   tot_q, tot_nxt, sym_count_nxt;
    logic [MAX_LEN-1:0] acc, acc_nxt;
    logic [LEN_W-1:0]   cur_len, cur_len_nxt;
    logic [IDX_W-1:0]   scan_idx, scan_idx_nxt;
    logic               cb_rd_en_nxt, finished_nxt, error_nxt;
    logic [SYM_W-1:0]   cb_addr_nxt, sym_data_nxt;

    logic               start_ok_c, load_c, bit_c, discard_c, hit_c, scan_end_c, last_c;
    logic [3:0]         bits_left;
    logic [LEN_W-1:0]   ent_len_c;
    logic [MAX_LEN-1:0] ent_code_c, len_mask_c;

    assign start_ok_c = start && (state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign last_c     = (sym_count + CNT_W'(1)) == tot_q;
    assign discard_c  = start_ok_c || (state == ST_EMIT && bus.sym_ready && last_c);
    assign bus.sym_valid = (state == ST_EMIT);

    t05_bit_unpacker u_unpacker (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (state == ST_FETCH),
        .shift_en   (state == ST_SHIFT),
        .discard    (discard_c),
        .in_data    (bus.in_data),
        .in_valid   (bus.in_valid),
        .in_ready_c (bus.in_ready),
        .load_c     (load_c),
        .bit_c      (bit_c),
        .bits_left  (bits_left)
    );

    // Entry returned this cycle belongs to index scan_idx-1.
    assign ent_len_c  = LEN_W'(cb_entry_len(CB_MAX_W'(bus.cb_data), MAX_LEN));
    assign ent_code_c = MAX_LEN'(cb_entry_code(CB_MAX_W'(bus.cb_data), MAX_LEN));
    assign len_mask_c = ~({MAX_LEN{1'b1}} << cur_len);
    assign hit_c      = (state == ST_SCAN) && (scan_idx != '0) && (ent_len_c != '0) &&
                        (ent_len_c == cur_len) && ((ent_code_c & len_mask_c) == acc);
    assign scan_end_c = (scan_idx == IDX_W'(NUM_SYMS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR:
                if (start) state_nxt = (tot_syms == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: if (load_c) state_nxt = ST_SHIFT;
            ST_SHIFT: state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (hit_c)                               state_nxt = ST_EMIT;
                else if (scan_end_c) begin
                    if (cur_len == LEN_W'(MAX_LEN))      state_nxt = ST_ERROR;
                    else if (bits_left != 4'd0)          state_nxt = ST_SHIFT;
                    else                                 state_nxt = ST_FETCH;
                end
            end
            ST_EMIT: begin
                if (bus.sym_ready) begin
                    if (last_c)                          state_nxt = ST_DONE;
                    else if (bits_left != 4'd0)          state_nxt = ST_SHIFT;
                    else                                 state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tot_nxt       = tot_q;
        sym_count_nxt = sym_count;
        acc_nxt       = acc;
        cur_len_nxt   = cur_len;
        scan_idx_nxt  = scan_idx;
        cb_rd_en_nxt  = 1'b0;
        cb_addr_nxt   = bus.cb_addr;
        sym_data_nxt  = bus.sym_data;
        finished_nxt  = finished;
        error_nxt     = error;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    tot_nxt       = tot_syms;
                    sym_count_nxt = '0;
                    acc_nxt       = '0;
                    cur_len_nxt   = '0;
                    error_nxt     = 1'b0;
                    finished_nxt  = (tot_syms == '0);
                end
            end
            ST_SHIFT: begin
                acc_nxt      = MAX_LEN'({acc, bit_c});
                cur_len_nxt  = cur_len + LEN_W'(1);
                scan_idx_nxt = '0;
                cb_rd_en_nxt = 1'b1;
                cb_addr_nxt  = '0;
            end
            ST_SCAN: begin
                if (hit_c) begin
                    sym_data_nxt = SYM_W'(scan_idx - IDX_W'(1));
                    acc_nxt      = '0;
                    cur_len_nxt  = '0;
                end else if (scan_end_c) begin
                    if (cur_len == LEN_W'(MAX_LEN)) error_nxt = 1'b1;
                end else begin
                    scan_idx_nxt = scan_idx + IDX_W'(1);
                    cb_rd_en_nxt = (scan_idx + IDX_W'(1)) < IDX_W'(NUM_SYMS);
                    cb_addr_nxt  = SYM_W'(scan_idx + IDX_W'(1));
                end
            end
            ST_EMIT: begin
                if (bus.sym_ready) begin
                    sym_count_nxt = sym_count + CNT_W'(1);
                    if (last_c) finished_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tot_q        <= '0;
            sym_count    <= '0;
            acc          <= '0;
            cur_len      <= '0;
            scan_idx     <= '0;
            bus.cb_rd_en <= 1'b0;
            bus.cb_addr  <= '0;
            bus.sym_data <= '0;
            finished     <= 1'b0;
            error        <= 1'b0;
        end else begin
            tot_q        <= tot_nxt;
            sym_count    <= sym_count_nxt;
            acc          <= acc_nxt;
            cur_len      <= cur_len_nxt;
            scan_idx     <= scan_idx_nxt;
            bus.cb_rd_en <= cb_rd_en_nxt;
            bus.cb_addr  <= cb_addr_nxt;
            bus.sym_data <= sym_data_nxt;
            finished     <= finished_nxt;
            error        <= error_nxt;
        end
    end
endmodule

// File: tb/tb_t05_huffman_stream_decode.sv
// Directed bench: default geometry decoder plus a small MAX_LEN=4 instance for the error path.
module tb_t05_huffman_stream_decode;
    localparam int unsigned SYM_W = 8, MAX_LEN = 127, LEN_W = 7, CNT_W = 32;
    localparam int unsigned NUM_SYMS = 2 ** SYM_W;
    localparam int unsigned E_SYM_W = 2, E_MAX_LEN = 4, E_LEN_W = 3, E_CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, finished, error;
    logic [CNT_W-1:0] tot_syms, sym_count;
    logic               e_start, e_finished, e_error;
    logic [E_CNT_W-1:0] e_tot, e_count;

    t05_huffman_stream_decode_if #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();
    t05_huffman_stream_decode_if #(.SYM_W(E_SYM_W), .MAX_LEN(E_MAX_LEN), .LEN_W(E_LEN_W)) ebus ();

    t05_huffman_stream_decode #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .tot_syms(tot_syms), .bus(bus),
        .sym_count(sym_count), .finished(finished), .error(error));

    t05_huffman_stream_decode #(.SYM_W(E_SYM_W), .MAX_LEN(E_MAX_LEN), .LEN_W(E_LEN_W), .CNT_W(E_CNT_W)) edut (
        .clk(clk), .rst(rst), .start(e_start), .tot_syms(e_tot), .bus(ebus),
        .sym_count(e_count), .finished(e_finished), .error(e_error));

    // Codebook SRAM models with a 1-cycle registered read
    logic [LEN_W+MAX_LEN-1:0]     cb_mem [NUM_SYMS];
    logic [E_LEN_W+E_MAX_LEN-1:0] e_cb_mem [4];
    always @(posedge clk) if (bus.cb_rd_en)  bus.cb_data  <= cb_mem[bus.cb_addr];
    always @(posedge clk) if (ebus.cb_rd_en) ebus.cb_data <= e_cb_mem[ebus.cb_addr];

    int n_checks = 0, n_errs = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LEN_W+MAX_LEN-1:0] mk(input int unsigned len, input logic [MAX_LEN-1:0] code);
        return {LEN_W'(len), code};
    endfunction

    // Byte source: a handshake seen as valid&&ready at a negedge completes at the next posedge
    logic [7:0] in_q [$];
    int  bytes_taken = 0;
    bit  take_pend = 0, ir_seen = 0;
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        forever begin
            @(negedge clk);
            if (take_pend && in_q.size() != 0) begin
                void'(in_q.pop_front());
                bytes_taken++;
            end
            if (bus.in_ready) ir_seen = 1'b1;
            bus.in_valid = (in_q.size() != 0);
            bus.in_data  = bus.in_valid ? in_q[0] : 8'h00;
            take_pend    = bus.in_valid && bus.in_ready;
        end
    end

    // Symbol sink with optional per-symbol stall
    logic [7:0] got_q [$];
    int   stall_cfg = 0, stall_left = 0;
    bit   in_sym = 0;
    logic [7:0] held;
    initial begin
        bus.sym_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!bus.sym_valid) begin
                bus.sym_ready = 1'b0;
                in_sym = 1'b0;
            end else begin
                if (!in_sym) begin
                    in_sym = 1'b1;
                    stall_left = stall_cfg;
                    held = bus.sym_data;
                end else if (!bus.sym_ready) begin
                    check_eq("stall_hold", 64'(bus.sym_data), 64'(held));
                end
                if (stall_left > 0) begin
                    bus.sym_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.sym_ready = 1'b1;
                    got_q.push_back(bus.sym_data);
                end
            end
        end
    end

    bit e_sv_seen = 0;
    initial forever begin
        @(negedge clk);
        if (ebus.sym_valid) e_sv_seen = 1'b1;
    end

    task automatic pulse_start(input logic [CNT_W-1:0] n);
        @(negedge clk);
        start = 1'b1;
        tot_syms = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finished(input int max_cycles);
        int i = 0;
        while (!finished && i < max_cycles) begin
            @(negedge clk);
            i++;
        end
        check_eq("finished", 64'(finished), 64'd1);
    endtask

    task automatic load_basic_cb();
        for (int i = 0; i < int'(NUM_SYMS); i++) cb_mem[i] = '0;
        cb_mem[0] = mk(1, 127'b0);
        cb_mem[1] = mk(2, 127'b10);
        cb_mem[2] = mk(2, 127'b11);
    endtask

    task automatic run_basic(input int stall);
        logic [7:0] exp_syms [5];
        exp_syms = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd0};
        load_basic_cb();
        got_q.delete();
        bytes_taken = 0;
        stall_cfg = stall;
        in_q.push_back(8'h5C);
        pulse_start(5);
        wait_finished(6000);
        check_eq("basic_nsyms", 64'(got_q.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("basic_sym%0d", i), 64'(got_q.size() > i ? got_q[i] : 8'hFF), 64'(exp_syms[i]));
        check_eq("basic_count", 64'(sym_count), 64'd5);
        check_eq("basic_noerr", 64'(error), 64'd0);
        repeat (20) @(negedge clk);
        check_eq("basic_bytes", 64'(bytes_taken), 64'd1);
        check_eq("basic_done_rdy", 64'(bus.in_ready), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int i;
        rst = 1'b0; start = 1'b0; tot_syms = '0;
        e_start = 1'b0; e_tot = '0;
        ebus.in_valid = 1'b1; ebus.in_data = 8'hFF; ebus.sym_ready = 1'b1;
        for (int k = 0; k < int'(NUM_SYMS); k++) cb_mem[k] = '0;
        e_cb_mem[0] = {3'd1, 4'b0000};
        e_cb_mem[1] = {3'd2, 4'b0010};
        e_cb_mem[2] = {3'd3, 4'b0110};
        e_cb_mem[3] = {3'd4, 4'b1110};
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_cb_rd_en", 64'(bus.cb_rd_en), 64'd0);
        check_eq("rst_sym_valid", 64'(bus.sym_valid), 64'd0);
        check_eq("rst_flags", 64'({finished, error}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Error path: "1111" has no code and MAX_LEN is 4; decision lands 25 edges after start
        @(negedge clk); e_start = 1'b1; e_tot = 8'd3;
        @(negedge clk); e_start = 1'b0;
        repeat (24) @(negedge clk);
        check_eq("err_early", 64'(e_error), 64'd0);
        @(negedge clk);
        check_eq("err_set", 64'(e_error), 64'd1);
        check_eq("err_in_ready", 64'(ebus.in_ready), 64'd0);
        check_eq("err_no_sym", 64'(e_sv_seen), 64'd0);
        repeat (5) @(negedge clk);
        check_eq("err_sticky", 64'(e_error), 64'd1);
        check_eq("err_cb_idle", 64'(ebus.cb_rd_en), 64'd0);
        @(negedge clk); e_start = 1'b1; e_tot = 8'd0;
        @(negedge clk); e_start = 1'b0;
        check_eq("err_cleared", 64'(e_error), 64'd0);
        check_eq("err_restart_fin", 64'(e_finished), 64'd1);

        // Basic decode and backpressure
        run_basic(0);
        run_basic(10);

        // Cross-byte code of length 9
        for (int k = 0; k < int'(NUM_SYMS); k++) cb_mem[k] = '0;
        cb_mem[7] = mk(9, 127'b000000001);
        got_q.delete();
        bytes_taken = 0;
        stall_cfg = 0;
        in_q.push_back(8'h00);
        in_q.push_back(8'h80);
        pulse_start(1);
        wait_finished(6000);
        check_eq("xb_nsyms", 64'(got_q.size()), 64'd1);
        check_eq("xb_sym", 64'(got_q.size() > 0 ? got_q[0] : 8'hFF), 64'd7);
        check_eq("xb_bytes", 64'(bytes_taken), 64'd2);
        check_eq("xb_count", 64'(sym_count), 64'd1);

        // Zero symbol count
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        check_eq("zc_pre_fin", 64'(finished), 64'd0);
        ir_seen = 1'b0;
        pulse_start(0);
        check_eq("zc_finished", 64'(finished), 64'd1);
        repeat (5) @(negedge clk);
        check_eq("zc_no_ready", 64'(ir_seen), 64'd0);
        check_eq("zc_count", 64'(sym_count), 64'd0);

        // Reset during a scan after two symbols, then a clean rerun
        load_basic_cb();
        got_q.delete();
        stall_cfg = 0;
        in_q.push_back(8'h5C);
        pulse_start(5);
        i = 0;
        while (!(got_q.size() >= 2 && bus.cb_rd_en) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check_eq("mid_reached_scan", 64'(bus.cb_rd_en), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_cb", 64'({bus.cb_rd_en, bus.cb_addr}), 64'd0);
        check_eq("mid_rst_sym", 64'({bus.sym_valid, bus.sym_data}), 64'd0);
        check_eq("mid_rst_count", 64'(sym_count), 64'd0);
        check_eq("mid_rst_flags", 64'({bus.in_ready, finished, error}), 64'd0);
        in_q.delete();
        @(negedge clk); rst = 1'b1;
        run_basic(0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/t05_huffman_stream_decode.md
# t05_huffman_stream_decode

Parametrised streaming Huffman decoder: the next generation of the team-05 translation/decode stage. It consumes the compressed file as a byte stream with a valid/ready handshake. Bits are decoded MSB-first against a length-tagged codebook held in SRAM with 1-cycle read latency. Decoded symbols are emitted on a valid/ready output until a programmed symbol count is reached. It sits between the SPI read path and the SPI write path, and is started by the top-level controller after header decode.

## Interface
- `SYM_W`, default 8: symbol width; `NUM_SYMS = 2**SYM_W` codebook entries.
- `MAX_LEN`, default 127: maximum code length in bits.
- `LEN_W`, default 7: width of the length field; must satisfy `2**LEN_W > MAX_LEN`.
- `CNT_W`, default 32: width of the symbol counters.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: 1-cycle pulse; accepted in IDLE, DONE or ERROR.
- `tot_syms` in CNT_W: number of symbols to decode; latched on `start`.
- `in_data` in 8: compressed byte, MSB is the first bit.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: decoder accepts a byte this cycle.
- `cb_rd_en` out 1: codebook read strobe.
- `cb_addr` out SYM_W: codebook entry index.
- `cb_data` in LEN_W+MAX_LEN: entry `{len, code}`, with the code right-aligned. Valid the cycle after `cb_rd_en`.
- `sym_data` out SYM_W: decoded symbol.
- `sym_valid` out 1: `sym_data` is valid.
- `sym_ready` in 1: the downstream stage takes the symbol.
- `sym_count` out CNT_W: number of symbols emitted since `start`.
- `finished` out 1: `tot_syms` symbols have been emitted. Held until the next `start`.
- `error` out 1: no code matched within `MAX_LEN` bits. Sticky until `start` or reset.

## Operation
- States: IDLE, FETCH, SHIFT, SCAN, EMIT, DONE, ERROR.
- IDLE → FETCH on `start`. If `tot_syms == 0`, go straight to DONE. On `start`: clear `sym_count`, the accumulator, `cur_len`, `finished` and `error`.
- FETCH:
  - `in_ready = 1`.
  - On `in_valid && in_ready`: load the byte, set `bits_left = 8`, go to SHIFT.
- SHIFT:
  - Shift the next MSB into the accumulator (`acc = {acc, bit}`), increment `cur_len`, decrement `bits_left`.
  - Go to SCAN with scan index `j = 0`.
- SCAN, cycle j:
  - If `j < NUM_SYMS`: assert `cb_rd_en` with `cb_addr = j`.
  - If `j >= 1`: compare `cb_data` (entry `j-1`). A match requires `len == cur_len` and the low `cur_len` bits of `code` equal to `acc`. Entries with `len == 0` never match.
- SCAN outcomes:
  - First match at entry k: go to EMIT with `sym_data = k` (lowest index wins). Clear `acc` and `cur_len`.
  - No match after comparing entry `NUM_SYMS-1`, with `cur_len == MAX_LEN`: go to ERROR.
  - Otherwise: go to SHIFT if `bits_left > 0`, else FETCH.
- EMIT:
  - `sym_valid = 1`; `sym_data` is stable until the handshake.
  - On `sym_ready`: increment `sym_count`.
  - If the new count equals `tot_syms`: go to DONE and discard the remaining bits of the current byte (padding).
  - Else: go to SHIFT if `bits_left > 0`, else FETCH.
- DONE: `finished = 1`, `in_ready = 0`. `start` re-arms the decoder.
- ERROR: `error = 1`, all handshakes deasserted. `start` re-arms the decoder.
- `start` outside IDLE, DONE and ERROR is ignored.

## Timing
- Reset values are all 0: `in_ready`, `cb_rd_en`, `cb_addr`, `sym_data`, `sym_valid`, `sym_count`, `finished`, `error`. State resets to IDLE.
- All outputs are registered, except `in_ready` and `sym_valid`, which decode directly from the state.
- Per bit: 1 SHIFT cycle plus at most `NUM_SYMS+1` SCAN cycles. A match on entry k costs `k+2` SCAN cycles.
- Byte fetch takes at least 1 cycle. Symbol emit takes at least 1 cycle and stalls indefinitely while `sym_ready` is low.
- `finished` rises in the cycle after the final `sym_valid && sym_ready`.
- Asserting `rst` mid-operation clears everything immediately. No partial symbol is emitted.

## Structure
- Shared package `t05_huffman_pkg` holds:
  - the state enum `huff_state_t`;
  - a `cb_entry_len`/`cb_entry_code` field-slicing function.
- A natural sub-module is `t05_bit_unpacker`: byte load plus MSB-first shift with `bits_left`. It owns `in_ready`/FETCH handling.
- The codebook is external. The bench models it as an array with a 1-cycle registered read.

## Test plan
- Basic decode. Codebook: sym0 = "0" (len 1), sym1 = "10", sym2 = "11"; all other entries len 0. Inputs: `tot_syms = 5`, one byte `0x5C`. Expected: symbols 0, 1, 2, 1, 0 emitted; `finished = 1`; `sym_count = 5`; no second byte is requested.
- Backpressure. Same stream with `sym_ready` held low for 10 cycles on each symbol. Expected: `sym_data` stays stable while stalled; same output sequence as the basic decode.
- Cross-byte code. Codebook: sym7 = "000000001" (len 9). Inputs: bytes `0x00`, `0x80`, `tot_syms = 1`. Expected: symbol 7; trailing padding bits ignored; `finished = 1`.
- Error. Set `MAX_LEN = 4`, no code of length ≤ 4 matching "1111", input `0xFF`. Expected: `error = 1` after the 4th bit's scan; `in_ready` and `sym_valid` stay at 0; `start` clears `error`.
- Zero count. `start` with `tot_syms = 0`. Expected: `finished = 1` on the next cycle; `in_ready` never asserted.
- Reset mid-scan. Drive `rst` low during SCAN of the basic decode. Expected: all outputs 0 immediately; a restarted run gives the correct sequence.
